// File: rtl/mccu_period_ctrl.sv
// rtl/mccu_period_ctrl.sv - periodic quota reload controller for the MCCU
module mccu_period_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int N_CORES      = 2,
    parameter int PERIOD_WIDTH = 32,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic                          stop_i,
    input  logic [PERIOD_WIDTH-1:0]       period_i,
    input  logic [N_CORES*DATA_WIDTH-1:0] reload_quota_i,
    input  logic                          halt_on_irq_i,
    input  logic [N_CORES-1:0]            irq_i,
    input  logic [N_CORES-1:0]            irq_ack_i,
    output logic                          mccu_enable_o,
    output logic [N_CORES-1:0]            update_quota_o,
    output logic [N_CORES*DATA_WIDTH-1:0] quota_o,
    output logic [N_CORES-1:0]            irq_sticky_o,
    output logic [PERIOD_WIDTH-1:0]       cnt_o,
    output logic [CNT_WIDTH-1:0]          periods_done_o,
    output logic [1:0]                    state_o
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] RUN  = 2'b10;
    localparam logic [1:0] HALT = 2'b11;

    logic                    period_valid;
    logic                    start_ok;
    logic                    halt_req;
    logic [PERIOD_WIDTH-1:0] period_m1;

    assign period_valid  = (period_i != '0);
    assign start_ok      = start_i && period_valid && (state_o != LOAD);
    assign halt_req      = halt_on_irq_i && (|irq_i);
    assign period_m1     = period_i - PERIOD_WIDTH'(1);
    assign mccu_enable_o = (state_o == RUN);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_o        <= IDLE;
            update_quota_o <= '0;
            quota_o        <= '0;
            cnt_o          <= '0;
            periods_done_o <= '0;
        end else begin
            update_quota_o <= '0;
            if (stop_i) begin
                state_o <= IDLE;
            end else if (start_ok) begin
                state_o        <= LOAD;
                cnt_o          <= period_m1;
                quota_o        <= reload_quota_i;
                update_quota_o <= '1;
                periods_done_o <= '0;
            end else begin
                case (state_o)
                    LOAD: state_o <= RUN;
                    RUN: begin
                        // The halt edge still consumes the current cycle; the count freezes afterwards.
                        if (halt_req) begin
                            state_o <= HALT;
                            if (cnt_o != '0) cnt_o <= cnt_o - PERIOD_WIDTH'(1);
                        end else if (cnt_o == '0) begin
                            if (period_valid) begin
                                cnt_o          <= period_m1;
                                quota_o        <= reload_quota_i;
                                update_quota_o <= '1;
                                if (periods_done_o != '1)
                                    periods_done_o <= periods_done_o + CNT_WIDTH'(1);
                            end else begin
                                state_o <= IDLE;
                            end
                        end else begin
                            cnt_o <= cnt_o - PERIOD_WIDTH'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Set wins over acknowledge so an overrun in the ack cycle is never lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) irq_sticky_o <= '0;
        else       irq_sticky_o <= (irq_sticky_o & ~irq_ack_i) | (irq_i & {N_CORES{mccu_enable_o}});
    end

endmodule

// File: tb/tb_mccu_period_ctrl.sv
// tb/tb_mccu_period_ctrl.sv - self-checking bench for mccu_period_ctrl
module tb_mccu_period_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, halt_on_irq = 1'b0;
    logic [31:0] period = '0;
    logic [63:0] reload = '0;
    logic [1:0]  irq = '0, ack = '0;

    logic        enable, enable2;
    logic [1:0]  update, update2, sticky, sticky2, state, state2;
    logic [63:0] quota, quota2;
    logic [31:0] cnt, cnt2;
    logic [15:0] done;
    logic [1:0]  done2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mccu_period_ctrl dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .period_i(period),
        .reload_quota_i(reload), .halt_on_irq_i(halt_on_irq), .irq_i(irq), .irq_ack_i(ack),
        .mccu_enable_o(enable), .update_quota_o(update), .quota_o(quota),
        .irq_sticky_o(sticky), .cnt_o(cnt), .periods_done_o(done), .state_o(state)
    );

    mccu_period_ctrl #(.CNT_WIDTH(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .period_i(period),
        .reload_quota_i(reload), .halt_on_irq_i(halt_on_irq), .irq_i(irq), .irq_ack_i(ack),
        .mccu_enable_o(enable2), .update_quota_o(update2), .quota_o(quota2),
        .irq_sticky_o(sticky2), .cnt_o(cnt2), .periods_done_o(done2), .state_o(state2)
    );

    // Behavioural reference: modes with remaining-cycle arithmetic.
    typedef enum {M_IDLE, M_LOAD, M_RUN, M_HALT} mode_t;
    mode_t       m_mode;
    int unsigned m_rem, m_done, m_done2;
    logic [63:0] m_quota;
    logic [1:0]  m_upd, m_sticky;

    function automatic logic [1:0] mode_code(mode_t m);
        case (m)
            M_LOAD:  return 2'b01;
            M_RUN:   return 2'b10;
            M_HALT:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_rem = 0; m_done = 0; m_done2 = 0;
        m_quota = '0; m_upd = '0; m_sticky = '0;
    endtask

    task automatic model_step();
        bit running;
        running = (m_mode == M_RUN);
        for (int i = 0; i < 2; i++) begin
            if (irq[i] && running) m_sticky[i] = 1'b1;
            else if (ack[i])       m_sticky[i] = 1'b0;
        end
        m_upd = 2'b00;
        if (stop) begin
            m_mode = M_IDLE;
        end else if (start && period != 0 && m_mode != M_LOAD) begin
            m_mode = M_LOAD; m_rem = period - 1; m_quota = reload; m_upd = 2'b11;
            m_done = 0; m_done2 = 0;
        end else if (m_mode == M_LOAD) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (halt_on_irq && irq != 0) begin
                m_mode = M_HALT;
                m_rem = (m_rem > 0) ? m_rem - 1 : 0;
            end else if (m_rem == 0) begin
                if (period != 0) begin
                    m_rem = period - 1; m_quota = reload; m_upd = 2'b11;
                    m_done = (m_done < 65535) ? m_done + 1 : 65535;
                    m_done2 = (m_done2 < 3) ? m_done2 + 1 : 3;
                end else begin
                    m_mode = M_IDLE;
                end
            end else begin
                m_rem = m_rem - 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #23;
        tests++; if (state !== 2'b00 || enable !== 1'b0 || update !== 2'b00) begin
            fails++; $display("FAIL reset_ctrl: state=%b en=%b upd=%b, want 00/0/00", state, enable, update); end
        tests++; if (quota !== '0 || sticky !== 2'b00 || cnt !== '0 || done !== '0) begin
            fails++; $display("FAIL reset_data: quota=%h sticky=%b cnt=%0d done=%0d, want zeros", quota, sticky, cnt, done); end
        @(posedge clk); #1; rst = 1'b0;
        repeat (4) tick();
        tests++; if (state !== 2'b00 || update !== 2'b00) begin
            fails++; $display("FAIL idle_no_start: state=%b upd=%b, want 00/00", state, update); end
    endtask

    task automatic test_reload();
        int nstrobe = 0;
        period = 4; reload = {32'd100, 32'd200}; start = 1'b1;
        tick(); start = 1'b0;
        tests++; if (state !== 2'b01 || update !== 2'b11 || quota !== {32'd100, 32'd200} || cnt !== 32'd3) begin
            fails++; $display("FAIL load_cycle: state=%b upd=%b quota=%h cnt=%0d, want 01/11/{100,200}/3", state, update, quota, cnt); end
        tick();
        tests++; if (state !== 2'b10 || update !== 2'b00 || cnt !== 32'd3 || enable !== 1'b1) begin
            fails++; $display("FAIL run_entry: state=%b upd=%b cnt=%0d en=%b, want 10/00/3/1", state, update, cnt, enable); end
        for (int idx = 1; idx <= 12; idx++) begin
            tick();
            if (update !== 2'b00) begin
                nstrobe++;
                tests++; if (idx != 4 * nstrobe || done !== 16'(nstrobe) || cnt !== 32'd3) begin
                    fails++; $display("FAIL reload_strobe: at=%0d done=%0d cnt=%0d, want %0d/%0d/3", idx, done, cnt, 4 * nstrobe, nstrobe); end
            end
        end
        tests++; if (nstrobe != 3) begin
            fails++; $display("FAIL strobe_count: got %0d, want 3", nstrobe); end
    endtask

    task automatic test_halt();
        int guard = 0;
        stop = 1'b1; tick(); stop = 1'b0;
        period = 8; start = 1'b1; tick(); start = 1'b0; tick();
        while (cnt !== 32'd2 && guard < 20) begin tick(); guard++; end
        tests++; if (cnt !== 32'd2) begin
            fails++; $display("FAIL halt_wait: cnt=%0d, want 2 within budget", cnt); end
        halt_on_irq = 1'b1; irq = 2'b10;
        tick();
        irq = 2'b00; halt_on_irq = 1'b0;
        tests++; if (state !== 2'b11 || enable !== 1'b0 || cnt !== 32'd1 || sticky !== 2'b10) begin
            fails++; $display("FAIL halt_enter: state=%b en=%b cnt=%0d sticky=%b, want 11/0/1/10", state, enable, cnt, sticky); end
        tick();
        tests++; if (state !== 2'b11 || cnt !== 32'd1) begin
            fails++; $display("FAIL halt_hold: state=%b cnt=%0d, want 11/1", state, cnt); end
        ack = 2'b10; tick(); ack = 2'b00;
        tests++; if (sticky !== 2'b00) begin
            fails++; $display("FAIL sticky_ack: sticky=%b, want 00", sticky); end
        start = 1'b1; tick(); start = 1'b0;
        tests++; if (state !== 2'b01 || update !== 2'b11) begin
            fails++; $display("FAIL halt_restart: state=%b upd=%b, want 01/11", state, update); end
    endtask

    task automatic test_start_ignored();
        stop = 1'b1; tick(); stop = 1'b0;
        period = 0; start = 1'b1; tick(); start = 1'b0;
        tests++; if (state !== 2'b00 || update !== 2'b00) begin
            fails++; $display("FAIL start_ignored: state=%b upd=%b, want 00/00", state, update); end
    endtask

    task automatic test_simultaneous();
        ack = 2'b11; tick(); ack = 2'b00;
        period = 5; start = 1'b1; tick(); start = 1'b0; tick();
        irq = 2'b01; ack = 2'b01; tick(); irq = 2'b00; ack = 2'b00;
        tests++; if (sticky !== 2'b01) begin
            fails++; $display("FAIL set_beats_ack: sticky=%b, want 01", sticky); end
        stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
        tests++; if (state !== 2'b00 || update !== 2'b00 || sticky !== 2'b01) begin
            fails++; $display("FAIL stop_beats_start: state=%b upd=%b sticky=%b, want 00/00/01", state, update, sticky); end
    endtask

    task automatic test_saturation();
        period = 1; start = 1'b1; tick(); start = 1'b0;
        repeat (7) tick();
        tests++; if (done2 !== 2'd3 || done !== 16'd6) begin
            fails++; $display("FAIL saturation: narrow=%0d wide=%0d, want 3/6", done2, done); end
    endtask

    task automatic test_async_reset();
        tests++; if (enable !== 1'b1) begin
            fails++; $display("FAIL pre_reset_run: en=%b, want 1", enable); end
        rst = 1'b1; #1;
        tests++; if (enable !== 1'b0 || state !== 2'b00 || cnt !== '0 || quota !== '0 || done !== '0) begin
            fails++; $display("FAIL async_reset: en=%b state=%b cnt=%0d quota=%h done=%0d, want zeros", enable, state, cnt, quota, done); end
        #2; rst = 1'b0;
        repeat (3) tick();
        tests++; if (state !== 2'b00) begin
            fails++; $display("FAIL post_reset_idle: state=%b, want 00", state); end
    endtask

    task automatic test_random();
        rst = 1'b1; #2; rst = 1'b0;
        model_reset();
        start = 0; stop = 0; irq = 0; ack = 0; halt_on_irq = 0; period = 3;
        for (int c = 0; c < 1500; c++) begin
            start = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 15) == 0)
                period = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 6));
            reload = {$urandom, $urandom};
            halt_on_irq = ($urandom_range(0, 3) == 0);
            irq = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
            ack = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            @(posedge clk);
            model_step();
            #1;
            tests++; if (state !== mode_code(m_mode) || enable !== (m_mode == M_RUN)) begin
                fails++; $display("FAIL rnd_state c=%0d: state=%b en=%b, want %b/%b", c, state, enable, mode_code(m_mode), m_mode == M_RUN); end
            tests++; if (update !== m_upd || quota !== m_quota) begin
                fails++; $display("FAIL rnd_update c=%0d: upd=%b quota=%h, want %b/%h", c, update, quota, m_upd, m_quota); end
            tests++; if (cnt !== m_rem || done !== 16'(m_done) || done2 !== 2'(m_done2)) begin
                fails++; $display("FAIL rnd_count c=%0d: cnt=%0d done=%0d sat=%0d, want %0d/%0d/%0d", c, cnt, done, done2, m_rem, m_done, m_done2); end
            tests++; if (sticky !== m_sticky) begin
                fails++; $display("FAIL rnd_sticky c=%0d: sticky=%b, want %b", c, sticky, m_sticky); end
        end
        start = 0; stop = 0; irq = 0; ack = 0; halt_on_irq = 0;
    endtask

    initial begin
        test_reset();
        test_reload();
        test_halt();
        test_start_ignored();
        test_simultaneous();
        test_saturation();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
